// File: rtl/key_filter_pkg.sv
// Shared constants, types and width helpers for the multi-channel key filter.
package key_filter_pkg;

    // 10 ms debounce and 1 s long-press at a 50 MHz system clock.
    localparam int   KF_DEBOUNCE_DEFAULT = 500000;
    localparam int   KF_LONG_DEFAULT     = 50000000;

    // Raw pin level of a released key (pull-up to the rail, switch to ground).
    localparam logic KF_IDLE_LEVEL       = 1'b1;

    // One-cycle event flags produced by a channel on each clock.
    typedef struct packed {
        logic press;
        logic rel;
        logic lng;
    } kf_evt_t;

    // Ceiling log2; kf_clog2(1) = 0.
    function automatic int kf_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width able to hold value-1, never narrower than one bit.
    function automatic int kf_cnt_w(input int value);
        return (kf_clog2(value) < 1) ? 1 : kf_clog2(value);
    endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-flop synchroniser, restartable debounce counter,
// accepted pressed level with press/release pulses, and long-press detection.
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = KF_DEBOUNCE_DEFAULT,
    parameter int   LONG_CYCLES     = KF_LONG_DEFAULT,
    parameter logic IDLE_LEVEL      = KF_IDLE_LEVEL
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int DW = kf_cnt_w(DEBOUNCE_CYCLES);
    localparam int LW = kf_cnt_w(LONG_CYCLES);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_dcnt;
    logic          r_pressed;
    logic [LW-1:0] r_lcnt;
    logic          r_long_done;
    kf_evt_t       r_evt;

    logic          w_stable_lvl;
    logic          w_differ;
    logic          w_accept;
    logic          w_long_hit;

    // Accepted state expressed as the raw pin level it corresponds to.
    assign w_stable_lvl = r_pressed ? ~IDLE_LEVEL : IDLE_LEVEL;
    assign w_differ     = (r_sync2 != w_stable_lvl);
    assign w_accept     = w_differ && (r_dcnt == DCNT_LAST);

    // A release accepted on the threshold cycle suppresses the long pulse.
    assign w_long_hit   = r_pressed && !w_accept && !r_long_done && (r_lcnt == LCNT_LAST);

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive cycles the synchronised level disagrees with the accepted one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dcnt <= '0;
        end else if (!w_differ || w_accept) begin
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
        end
    end

    // Toggle the accepted level and raise exactly one event flag per accept or threshold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pressed <= 1'b0;
            r_evt     <= '0;
        end else begin
            r_evt.press <= w_accept && !r_pressed;
            r_evt.rel   <= w_accept &&  r_pressed;
            r_evt.lng   <= w_long_hit;
            if (w_accept) begin
                r_pressed <= ~r_pressed;
            end
        end
    end

    // Time the hold after acceptance; saturate and latch done until release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
        end else if (!r_pressed || w_accept) begin
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
        end else if (w_long_hit) begin
            r_long_done <= 1'b1;
        end else if (!r_long_done) begin
            r_lcnt      <= r_lcnt + 1'b1;
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_evt.press;
    assign o_release_pulse = r_evt.rel;
    assign o_long_pulse    = r_evt.lng;

endmodule

// File: rtl/key_filter_multi.sv
// N-channel key debouncer: fans the key bus out to independent channel filters.
module key_filter_multi
    import key_filter_pkg::*;
#(
    parameter int   N_KEYS          = 4,
    parameter int   DEBOUNCE_CYCLES = KF_DEBOUNCE_DEFAULT,
    parameter int   LONG_CYCLES     = KF_LONG_DEFAULT,
    parameter logic IDLE_LEVEL      = KF_IDLE_LEVEL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_filter_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_chan (
            .i_clk           (clk),
            .i_rst           (rst),
            .i_key           (key[g]),
            .o_pressed       (key_pressed[g]),
            .o_press_pulse   (press_pulse[g]),
            .o_release_pulse (release_pulse[g]),
            .o_long_pulse    (long_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: directed scenarios plus randomized key chatter,
// every cycle compared with a sliding-window reference model.
module tb_key_filter_multi;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int LG = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key;
    logic [NK-1:0] key_pressed;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] long_pulse;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw samples, window of synchronised levels, accepted state, hold age.
    bit            m_samp [NK][$];
    bit            m_win  [NK][$];
    bit            m_pr   [NK];
    int            m_age  [NK];
    logic [NK-1:0] e_pr, e_press, e_rel, e_long;

    always #5 clk = ~clk;

    key_filter_multi #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key           (key),
        .key_pressed   (key_pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NK; c++) begin
            m_samp[c].delete();
            m_samp[c].push_back(1'b1);
            m_samp[c].push_back(1'b1);
            m_win[c].delete();
            for (int i = 0; i < DB; i++) m_win[c].push_back(1'b1);
            m_pr[c]  = 1'b0;
            m_age[c] = 0;
        end
        e_pr = '0; e_press = '0; e_rel = '0; e_long = '0;
    endtask

    // A level change is accepted when the last DB synchronised samples all
    // disagree with the accepted state; the synchronised sample is the raw
    // key as seen two edges earlier.
    task automatic model_edge();
        bit kpre;
        bit acc;
        bit stable_lvl;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NK; c++) begin
            kpre = m_samp[c][0];
            void'(m_samp[c].pop_front());
            m_samp[c].push_back(key[c]);
            void'(m_win[c].pop_front());
            m_win[c].push_back(kpre);
            stable_lvl = m_pr[c] ? 1'b0 : 1'b1;
            acc = 1'b1;
            for (int i = 0; i < m_win[c].size(); i++)
                if (m_win[c][i] == stable_lvl) acc = 1'b0;
            e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
            if (acc) begin
                if (!m_pr[c]) begin
                    m_pr[c] = 1'b1; e_press[c] = 1'b1; m_age[c] = 0;
                end else begin
                    m_pr[c] = 1'b0; e_rel[c] = 1'b1;
                end
            end else if (m_pr[c]) begin
                m_age[c]++;
                if (m_age[c] == LG) e_long[c] = 1'b1;
            end
            e_pr[c] = m_pr[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("key_pressed", key_pressed, e_pr);
        check("press_pulse", press_pulse, e_press);
        check("release_pulse", release_pulse, e_rel);
        check("long_pulse", long_pulse, e_long);
    endtask

    // kind: 0 press, 1 release, 2 long. n = edges ticked until the event (limit if none).
    task automatic wait_evt(input int kind, input int ch, input int limit, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            tick();
            n++;
            case (kind)
                0:       hit = press_pulse[ch];
                1:       hit = release_pulse[ch];
                default: hit = long_pulse[ch];
            endcase
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_pressed"}, key_pressed, '0);
        check({tag, "_pulses"}, press_pulse | release_pulse | long_pulse, '0);
        model_reset();
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int lc;
        int mode;
        int len;

        // 1: reset with keys idle
        rst = 1'b1;
        key = 2'b11;
        model_reset();
        #1;
        check("reset_pressed", key_pressed, '0);
        check("reset_pulses", press_pulse | release_pulse | long_pulse, '0);
        repeat (5) tick();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

        // 2: clean press on key 0
        key[0] = 1'b0;
        wait_evt(0, 0, 20, n);
        check_int("press_latency", n, DB + 2);
        check("press_level", key_pressed, 2'b01);
        tick();
        check("press_one_cycle", press_pulse, 2'b00);
        key[0] = 1'b1;
        wait_evt(1, 0, 20, n);
        check_int("release_latency", n, DB + 2);

        // 3: one-cycle glitch while the debounce count is at 3
        key[0] = 1'b0;
        repeat (3) tick();
        key[0] = 1'b1;
        tick();
        key[0] = 1'b0;
        wait_evt(0, 0, 20, n);
        check_int("glitch_restart_latency", n, 6);

        // 4: hold for long press, exactly one long pulse
        wait_evt(2, 0, 30, n);
        check_int("long_latency", n, LG);
        lc = 0;
        repeat (15) begin
            tick();
            lc += int'(long_pulse[0]);
        end
        check_int("long_once", lc, 0);
        key[0] = 1'b1;
        wait_evt(1, 0, 20, n);
        check_int("long_release_latency", n, DB + 2);

        // 5: short hold then release, no long pulse
        key[0] = 1'b0;
        wait_evt(0, 0, 20, n);
        repeat (5) tick();
        key[0] = 1'b1;
        wait_evt(1, 0, 20, n);
        check_int("short_release_latency", n, DB + 2);

        // 5b: release accepted on the very cycle the long threshold is reached
        key[0] = 1'b0;
        wait_evt(0, 0, 20, n);
        repeat (4) tick();
        key[0] = 1'b1;
        wait_evt(1, 0, 20, n);
        check_int("threshold_release_latency", n, DB + 2);
        check("threshold_no_long", long_pulse, 2'b00);
        repeat (3) tick();

        // 5c: both keys pressed together
        key = 2'b00;
        wait_evt(0, 0, 20, n);
        check("both_press", press_pulse, 2'b11);

        // 6: reset while key 1 held, then re-acceptance after reset
        key = 2'b01;
        wait_evt(1, 0, 20, n);
        tick();
        check("before_reset_level", key_pressed, 2'b10);
        async_reset("midpress_reset");
        wait_evt(0, 1, 20, n);
        check_int("post_reset_press_latency", n, DB + 2);
        key = 2'b11;
        repeat (12) tick();

        // Randomized segments: chatter, slow toggling and long holds, with occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(5, 80);
            if ($urandom_range(0, 9) == 0) async_reset("rand_reset");
            for (int i = 0; i < len; i++) begin
                for (int c = 0; c < NK; c++) begin
                    if (mode == 0 && $urandom_range(0, 1) == 0) key[c] = ~key[c];
                    if (mode == 1 && $urandom_range(0, 11) == 0) key[c] = ~key[c];
                end
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
